// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for the ALU-path blocks.
//   - FSM state encodings used by serial_adder (2-bit, legacy-compatible).
//   - Default operand width.
package alu_pkg;

    localparam int WIDTH_DEF = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/serial_adder_fa.sv
// serial_adder_fa: combinational single-bit full adder, the datapath cell of
// serial_adder.
// Ports:
//   a, b  : operand bits
//   cin   : carry in
//   s     : sum bit
//   cout  : carry out
module serial_adder_fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial add/subtract, one bit per clock, LSB first,
// through a single full adder with a registered carry.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   start     : request, accepted in IDLE or DONE only
//   sub       : 0 = a+b, 1 = a-b (sampled with start)
//   a, b      : WIDTH-bit operands (sampled with start)
//   busy      : high while bits are being processed
//   done      : one-cycle pulse, result valid
//   sum       : result, held until the next done
//   cout      : final carry (for subtract: 1 = no borrow)
//   overflow  : two's-complement overflow
module serial_adder
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [1:0]       state;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_s;
    logic             fa_c;
    logic             last_bit;

    serial_adder_fa u_fa (
        .a    (sh_a[0]),
        .b    (sh_b[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_c)
    );

    assign last_bit = (cnt == CW'(WIDTH - 1));
    assign busy     = (state == ST_RUN);
    assign done     = (state == ST_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            sh_a     <= '0;
            sh_b     <= '0;
            res      <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        // Subtract as a + ~b + 1: the +1 enters as the initial carry.
                        sh_a  <= a;
                        sh_b  <= sub ? ~b : b;
                        carry <= sub;
                        cnt   <= '0;
                        res   <= '0;
                        state <= ST_RUN;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    res   <= {fa_s, res[WIDTH-1:1]};
                    sh_a  <= sh_a >> 1;
                    sh_b  <= sh_b >> 1;
                    carry <= fa_c;
                    cnt   <= cnt + 1'b1;
                    if (last_bit) begin
                        // On the MSB cycle, carry holds the MSB carry-in (c_msb)
                        // and fa_c is the carry-out; their XOR is signed overflow.
                        // Outputs are registered here so they stay put through
                        // any following RUN until the next DONE.
                        sum      <= {fa_s, res[WIDTH-1:1]};
                        cout     <= fa_c;
                        overflow <= carry ^ fa_c;
                        state    <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
